sdram_port_arbiter: RTL and testbench

- Parametrised multi-client front end for sdram_core. Generalises the fixed drawunit/vgadisplay pairing to NUM_PORTS burst clients.
- Grants one client at a time and forwards one burst command to the controller.
- Routes write beats from, and read beats to, the granted client; signals completion.
- Display scan-out (RT_PORT) gets priority, bounded by a starvation guard; all other ports are round-robin.

---
 rtl/sdram_port_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_sdram_port_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_port_arbiter.sv
// Multi-client burst arbiter in front of sdram_core: one grant at a time,
// RT_PORT priority with a starvation guard, round-robin for the rest.
//
// Ports:
//   clk_50m, rst_n          clock, async active-low reset
//   p_req/p_we/p_addr/p_len per-client burst request (packed per port)
//   p_wdata                 per-client FWFT write data
//   p_gnt/p_wpop/p_rvalid   per-client accept / write-pop / read-valid strobes
//   p_rdata, p_done         shared read data, per-client completion pulse
//   cmd_*                   command handshake to the controller
//   wr_req/wr_data          controller write-beat pull
//   rd_valid/rd_data        controller read beats
//   busy                    arbiter not idle
module sdram_port_arbiter #(
    parameter int NUM_PORTS  = 3,
    parameter int ADDR_W     = 24,
    parameter int DATA_W     = 16,
    parameter int LEN_W      = 4,
    parameter int RT_PORT    = 0,
    parameter int RT_MODE    = 1,
    parameter int MAX_RT_RUN = 4
) (
    input  logic                          clk_50m,
    input  logic                          rst_n,
    input  logic [NUM_PORTS-1:0]          p_req,
    input  logic [NUM_PORTS-1:0]          p_we,
    input  logic [NUM_PORTS*ADDR_W-1:0]   p_addr,
    input  logic [NUM_PORTS*LEN_W-1:0]    p_len,
    input  logic [NUM_PORTS*DATA_W-1:0]   p_wdata,
    output logic [NUM_PORTS-1:0]          p_gnt,
    output logic [NUM_PORTS-1:0]          p_wpop,
    output logic [NUM_PORTS-1:0]          p_rvalid,
    output logic [DATA_W-1:0]             p_rdata,
    output logic [NUM_PORTS-1:0]          p_done,
    output logic                          cmd_valid,
    input  logic                          cmd_ready,
    output logic                          cmd_we,
    output logic [ADDR_W-1:0]             cmd_addr,
    output logic [LEN_W-1:0]              cmd_len,
    input  logic                          wr_req,
    output logic [DATA_W-1:0]             wr_data,
    input  logic                          rd_valid,
    input  logic [DATA_W-1:0]             rd_data,
    output logic                          busy
);

    localparam int IDX_W = $clog2(NUM_PORTS);
    localparam int RUN_W = $clog2(MAX_RT_RUN + 2);

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        XFER
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] cur;
    logic [IDX_W-1:0] rr_ptr;
    logic             cur_we;
    logic [ADDR_W-1:0] cur_addr;
    logic [LEN_W-1:0] cur_len;
    logic [LEN_W-1:0] beat_cnt;
    logic [RUN_W-1:0] rt_run;
    logic             done_q;

    logic [NUM_PORTS-1:0] rt_mask;
    logic [NUM_PORTS-1:0] other_req;
    logic                 rt_win;
    logic                 rr_found;
    logic [IDX_W-1:0]     cand;
    logic [IDX_W-1:0]     rr_win;
    logic [IDX_W-1:0]     win;
    logic [IDX_W-1:0]     nxt_ptr;
    logic                 win_we;
    logic [ADDR_W-1:0]    win_addr;
    logic [LEN_W-1:0]     win_len;
    logic [DATA_W-1:0]    cur_wdata;
    logic                 xfer;
    logic                 beat;

    // RT wins unless it has used up its run while someone else waits.
    always_comb begin
        rt_mask = '0;
        if (RT_MODE != 0)
            rt_mask[RT_PORT] = 1'b1;
        other_req = p_req & ~rt_mask;
        rt_win = (RT_MODE != 0) && p_req[RT_PORT] &&
                 ((rt_run < RUN_W'(MAX_RT_RUN)) || (other_req == '0));
        rr_found = 1'b0;
        rr_win   = '0;
        cand     = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            cand = IDX_W'((int'(rr_ptr) + k) % NUM_PORTS);
            if (!rr_found && other_req[cand]) begin
                rr_found = 1'b1;
                rr_win   = cand;
            end
        end
        win = rt_win ? IDX_W'(RT_PORT) : rr_win;
        nxt_ptr = (rr_win == IDX_W'(NUM_PORTS - 1)) ? '0 : rr_win + 1'b1;
    end

    always_comb begin
        win_we    = 1'b0;
        win_addr  = '0;
        win_len   = '0;
        cur_wdata = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (win == IDX_W'(k)) begin
                win_we   = p_we[k];
                win_addr = p_addr[k*ADDR_W +: ADDR_W];
                win_len  = p_len[k*LEN_W +: LEN_W];
            end
            if (cur == IDX_W'(k))
                cur_wdata = p_wdata[k*DATA_W +: DATA_W];
        end
    end

    assign xfer = (state == XFER);
    assign beat = cur_we ? wr_req : rd_valid;

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cur      <= '0;
            rr_ptr   <= '0;
            cur_we   <= 1'b0;
            cur_addr <= '0;
            cur_len  <= '0;
            beat_cnt <= '0;
            rt_run   <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (|p_req) begin
                        cur      <= win;
                        cur_we   <= win_we;
                        cur_addr <= win_addr;
                        cur_len  <= win_len;
                        state    <= CMD;
                        if (rt_win) begin
                            if (rt_run != RUN_W'(MAX_RT_RUN))
                                rt_run <= rt_run + 1'b1;
                        end else begin
                            rr_ptr <= nxt_ptr;
                            rt_run <= '0;
                        end
                    end
                end
                CMD: begin
                    if (cmd_ready) begin
                        beat_cnt <= '0;
                        state    <= XFER;
                    end
                end
                XFER: begin
                    if (beat) begin
                        if (beat_cnt == cur_len) begin
                            state  <= IDLE;
                            done_q <= 1'b1;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign cmd_valid = (state == CMD);
    assign cmd_we    = cmd_valid & cur_we;
    assign cmd_addr  = cmd_valid ? cur_addr : '0;
    assign cmd_len   = cmd_valid ? cur_len : '0;
    assign busy      = (state != IDLE);
    assign wr_data   = (xfer & cur_we) ? cur_wdata : '0;
    assign p_rdata   = (xfer & ~cur_we) ? rd_data : '0;

    always_comb begin
        p_gnt    = '0;
        p_wpop   = '0;
        p_rvalid = '0;
        p_done   = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (cur == IDX_W'(k)) begin
                p_gnt[k]    = cmd_valid & cmd_ready;
                p_wpop[k]   = xfer & cur_we & wr_req;
                p_rvalid[k] = xfer & ~cur_we & rd_valid;
                p_done[k]   = done_q;
            end
        end
    end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter: table of bursts with expected
// winners, plus command back-pressure and mid-burst reset sequences.
module tb_sdram_port_arbiter;

    logic        clk_50m = 1'b0;
    logic        rst_n;
    logic [2:0]  p_req;
    logic [2:0]  p_we;
    logic [71:0] p_addr;
    logic [11:0] p_len;
    logic [47:0] p_wdata;
    logic        cmd_ready;
    logic        wr_req;
    logic        rd_valid;
    logic [15:0] rd_data;

    logic [2:0]  p_gnt, p_wpop, p_rvalid, p_done;
    logic [15:0] p_rdata, wr_data;
    logic        cmd_valid, cmd_we, busy;
    logic [23:0] cmd_addr;
    logic [3:0]  cmd_len;

    logic [2:0]  p_gnt_b, p_wpop_b, p_rvalid_b, p_done_b;
    logic [15:0] p_rdata_b, wr_data_b;
    logic        cmd_valid_b, cmd_we_b, busy_b;
    logic [23:0] cmd_addr_b;
    logic [3:0]  cmd_len_b;

    int checks = 0;
    int failures = 0;

    logic [23:0] addr_tab [3];

    typedef struct {
        logic [2:0] req;
        logic [2:0] we;
        int         port;
        int         len;
        int         delay;
        bit         drop;
        bit         chk_b;
    } vec_t;

    vec_t vecs [22];

    always #5 clk_50m = ~clk_50m;

    sdram_port_arbiter dut (
        .clk_50m(clk_50m), .rst_n(rst_n),
        .p_req(p_req), .p_we(p_we), .p_addr(p_addr),
        .p_len(p_len), .p_wdata(p_wdata),
        .p_gnt(p_gnt), .p_wpop(p_wpop), .p_rvalid(p_rvalid),
        .p_rdata(p_rdata), .p_done(p_done),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_we(cmd_we), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_req(wr_req), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_data(rd_data), .busy(busy)
    );

    sdram_port_arbiter #(.RT_MODE(0)) dut_rr (
        .clk_50m(clk_50m), .rst_n(rst_n),
        .p_req(p_req), .p_we(p_we), .p_addr(p_addr),
        .p_len(p_len), .p_wdata(p_wdata),
        .p_gnt(p_gnt_b), .p_wpop(p_wpop_b), .p_rvalid(p_rvalid_b),
        .p_rdata(p_rdata_b), .p_done(p_done_b),
        .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready),
        .cmd_we(cmd_we_b), .cmd_addr(cmd_addr_b), .cmd_len(cmd_len_b),
        .wr_req(wr_req), .wr_data(wr_data_b),
        .rd_valid(rd_valid), .rd_data(rd_data), .busy(busy_b)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] wdat(input int k, input int b);
        return 16'(32'hA000 + k * 256 + b);
    endfunction

    task automatic set_len(input int len);
        for (int k = 0; k < 3; k++)
            p_len[k*4 +: 4] = 4'(len);
    endtask

    task automatic run_burst(input int port, input logic we, input int len,
                             input int delay, input bit drop,
                             input bit chk_b, input int abort_at);
        int waited;
        logic [2:0] oh;
        oh = 3'b001 << port;
        waited = 0;
        cmd_ready = 1'b0;
        wr_req = 1'b1;
        rd_valid = 1'b1;
        @(negedge clk_50m);
        while (!cmd_valid && waited < 20) begin
            @(negedge clk_50m);
            waited++;
        end
        check("cmd_latency", waited, 0);
        for (int c = 0; c <= delay; c++) begin
            if (c > 0)
                @(negedge clk_50m);
            cmd_ready = (c == delay);
            #1;
            check("cmd_valid", cmd_valid, 1);
            check("cmd_addr", cmd_addr, addr_tab[port]);
            check("cmd_len", cmd_len, len);
            check("cmd_we", cmd_we, we);
            check("p_gnt", p_gnt, (c == delay) ? oh : 3'b000);
            check("cmd_strobes", {p_wpop, p_rvalid, p_done}, 0);
            if (chk_b)
                check("p_gnt_rr", p_gnt_b, (c == delay) ? oh : 3'b000);
        end
        @(negedge clk_50m);
        cmd_ready = 1'b0;
        wr_req = 1'b0;
        rd_valid = 1'b0;
        if (drop)
            p_req = 3'b000;
        #1;
        check("xfer_busy", busy, 1);
        check("gap_strobes", {p_gnt, p_wpop, p_rvalid, p_done}, 0);
        for (int b = 0; b <= len; b++) begin
            @(negedge clk_50m);
            for (int k = 0; k < 3; k++)
                p_wdata[k*16 +: 16] = wdat(k, b);
            wr_req = we;
            rd_valid = !we;
            rd_data = 16'hBEEF ^ 16'(b);
            if (b == abort_at)
                rst_n = 1'b0;
            #1;
            if (b == abort_at) begin
                check("abort_outs", {p_gnt, p_wpop, p_rvalid, p_done}, 0);
                check("abort_busy", {busy, cmd_valid, cmd_we}, 0);
                check("abort_data", {p_rdata, wr_data}, 0);
                check("abort_cmd", {cmd_addr, cmd_len}, 0);
                wr_req = 1'b0;
                rd_valid = 1'b0;
                return;
            end
            check("p_wpop", p_wpop, we ? oh : 3'b000);
            check("p_rvalid", p_rvalid, we ? 3'b000 : oh);
            if (we)
                check("wr_data", wr_data, wdat(port, b));
            else
                check("p_rdata", p_rdata, 16'hBEEF ^ 16'(b));
            check("p_done_early", p_done, 0);
        end
        @(negedge clk_50m);
        wr_req = 1'b0;
        rd_valid = 1'b0;
        #1;
        check("p_done", p_done, oh);
        check("busy_end", busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        addr_tab[0] = 24'h0A0000;
        addr_tab[1] = 24'h000100;
        addr_tab[2] = 24'h123456;
        p_addr = {addr_tab[2], addr_tab[1], addr_tab[0]};

        vecs[0]  = '{3'b010, 3'b010, 1, 3, 0, 0, 1};
        vecs[1]  = '{3'b110, 3'b000, 2, 1, 0, 0, 1};
        vecs[2]  = '{3'b110, 3'b000, 1, 1, 0, 0, 1};
        vecs[3]  = '{3'b110, 3'b000, 2, 1, 0, 0, 1};
        vecs[4]  = '{3'b110, 3'b000, 1, 1, 0, 0, 1};
        vecs[5]  = '{3'b011, 3'b010, 0, 0, 0, 0, 0};
        vecs[6]  = '{3'b011, 3'b010, 0, 0, 0, 0, 0};
        vecs[7]  = '{3'b011, 3'b010, 0, 0, 0, 0, 0};
        vecs[8]  = '{3'b011, 3'b010, 0, 0, 0, 0, 0};
        vecs[9]  = '{3'b011, 3'b010, 1, 0, 0, 0, 0};
        vecs[10] = '{3'b011, 3'b010, 0, 0, 0, 0, 0};
        vecs[11] = '{3'b011, 3'b010, 0, 0, 0, 0, 0};
        vecs[12] = '{3'b011, 3'b010, 0, 0, 0, 0, 0};
        vecs[13] = '{3'b011, 3'b010, 0, 0, 0, 0, 0};
        vecs[14] = '{3'b011, 3'b010, 1, 2, 0, 0, 0};
        vecs[15] = '{3'b100, 3'b100, 2, 15, 5, 0, 0};
        vecs[16] = '{3'b001, 3'b000, 0, 2, 0, 1, 0};
        vecs[17] = '{3'b001, 3'b000, 0, 0, 0, 0, 0};
        vecs[18] = '{3'b001, 3'b000, 0, 0, 0, 0, 0};
        vecs[19] = '{3'b001, 3'b000, 0, 0, 0, 0, 0};
        vecs[20] = '{3'b001, 3'b000, 0, 0, 1, 0, 0};
        vecs[21] = '{3'b011, 3'b000, 1, 0, 0, 0, 0};

        rst_n = 1'b0;
        p_req = 3'b000;
        p_we = 3'b000;
        p_len = '0;
        p_wdata = '0;
        cmd_ready = 1'b1;
        wr_req = 1'b1;
        rd_valid = 1'b1;
        rd_data = 16'hFFFF;
        repeat (2) @(negedge clk_50m);
        #1;
        check("rst_strobes", {p_gnt, p_wpop, p_rvalid, p_done}, 0);
        check("rst_ctl", {busy, cmd_valid, cmd_we}, 0);
        check("rst_data", {p_rdata, wr_data}, 0);
        check("rst_cmd", {cmd_addr, cmd_len}, 0);
        @(negedge clk_50m);
        rst_n = 1'b1;
        cmd_ready = 1'b0;
        wr_req = 1'b0;
        rd_valid = 1'b0;
        @(negedge clk_50m);
        #1;
        check("idle_busy", busy, 0);
        check("idle_cmd", cmd_valid, 0);

        for (int i = 0; i < 22; i++) begin
            p_req = vecs[i].req;
            p_we = vecs[i].we;
            set_len(vecs[i].len);
            run_burst(vecs[i].port, vecs[i].we[vecs[i].port],
                      vecs[i].len, vecs[i].delay, vecs[i].drop,
                      vecs[i].chk_b, -1);
        end

        // Port 1 read of 8 beats, reset during the 3rd beat.
        p_req = 3'b010;
        p_we = 3'b000;
        set_len(7);
        run_burst(1, 1'b0, 7, 0, 0, 0, 2);
        p_req = 3'b110;
        set_len(1);
        repeat (2) begin
            @(negedge clk_50m);
            #1;
            check("rst_no_done", p_done, 0);
            check("rst_idle", busy, 0);
        end
        @(negedge clk_50m);
        rst_n = 1'b1;
        run_burst(1, 1'b0, 1, 0, 0, 0, -1);
        p_req = 3'b000;
        repeat (3) @(negedge clk_50m);
        #1;
        check("final_idle", {busy, cmd_valid}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
